// File: rtl/adder_2.sv
// Registered 32-bit adder with carry/overflow/zero flags; two-level carry-lookahead datapath.
// Latency 1 cycle, no backpressure (one op per clk); outputs hold when in_valid is low.
module adder_2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             out_valid
);

    localparam int NGRP = WIDTH / 4;

    logic [WIDTH-1:0] bit_g, bit_p;
    logic [NGRP-1:0]  grp_g, grp_p;
    logic [NGRP:0]    grp_c;
    logic [NGRP:0]    grp_gen_ext;
    logic [WIDTH:0]   bit_c;
    logic [WIDTH-1:0] raw_sum;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             carry_out_d, carry_out_q;
    logic             overflow_d, overflow_q;
    logic             zero_d, zero_q;
    logic             out_valid_d, out_valid_q;

    always_comb begin
        logic [4:0] loc_ext;
        logic       term;
        logic       acc;

        bit_g       = a & b;
        bit_p       = a ^ b;
        grp_g       = '0;
        grp_p       = '0;
        grp_c       = '0;
        bit_c       = '0;
        loc_ext     = '0;
        term        = 1'b0;
        acc         = 1'b0;

        for (int i = 0; i < NGRP; i++) begin
            grp_p[i] = &bit_p[4*i +: 4];
            grp_g[i] = bit_g[4*i+3]
                     | (bit_p[4*i+3] & bit_g[4*i+2])
                     | (bit_p[4*i+3] & bit_p[4*i+2] & bit_g[4*i+1])
                     | ((&bit_p[4*i+1 +: 3]) & bit_g[4*i]);
        end

        // Second level: each group carry is a flat sum-of-products over all lower groups.
        grp_gen_ext = {grp_g, carry_in};
        for (int i = 0; i <= NGRP; i++) begin
            acc = 1'b0;
            for (int k = 0; k <= i; k++) begin
                term = grp_gen_ext[k];
                for (int m = k; m < i; m++) begin
                    term = term & grp_p[m];
                end
                acc = acc | term;
            end
            grp_c[i] = acc;
        end

        // First level: bit carries inside each group, seeded by that group's lookahead carry.
        for (int i = 0; i < NGRP; i++) begin
            loc_ext = {bit_g[4*i +: 4], grp_c[i]};
            for (int j = 0; j < 4; j++) begin
                acc = 1'b0;
                for (int k = 0; k <= j; k++) begin
                    term = loc_ext[k];
                    for (int m = k; m < j; m++) begin
                        term = term & bit_p[4*i+m];
                    end
                    acc = acc | term;
                end
                bit_c[4*i+j] = acc;
            end
        end
        bit_c[WIDTH] = grp_c[NGRP];
        raw_sum      = bit_p ^ bit_c[WIDTH-1:0];
    end

    always_comb begin
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        out_valid_d = in_valid;
        // The select keeps idle-cycle X on a/b out of the held result.
        if (in_valid) begin
            sum_d       = raw_sum;
            carry_out_d = bit_c[WIDTH];
            overflow_d  = (a[WIDTH-1] == b[WIDTH-1]) && (raw_sum[WIDTH-1] != a[WIDTH-1]);
            zero_d      = (raw_sum == '0);
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_2.sv
// Self-checking bench for adder_2: directed vector table, PC-increment run, hold/reset sequences, random ops.
module tb_adder_2;

    logic        clk;
    logic        clear;
    logic        in_valid;
    logic [31:0] a, b;
    logic        carry_in;
    logic [31:0] sum;
    logic        carry_out, overflow, zero, out_valid;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_s;
    logic        m_c, m_ov, m_z;

    adder_2 #(.WIDTH(32)) dut (
        .clk       (clk),
        .clear     (clear),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        c;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [31:0] s,
                           input logic c, input logic ov, input logic z);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".sum"},   sum, s);
        chk({tag, ".carry"}, {31'd0, carry_out}, {31'd0, c});
        chk({tag, ".ovf"},   {31'd0, overflow},  {31'd0, ov});
        chk({tag, ".zero"},  {31'd0, zero},      {31'd0, z});
    endtask

    // Reference: plain 33-bit unsigned sum and 64-bit signed range test.
    task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mc);
        logic [32:0] full;
        longint      sa;
        full = {1'b0, ma} + {1'b0, mb} + {32'd0, mc};
        sa   = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mc);
        m_s  = full[31:0];
        m_c  = full[32];
        m_ov = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
        m_z  = (full[31:0] == 32'd0);
    endtask

    task automatic cycle(input logic v, input logic [31:0] ca, input logic [31:0] cb, input logic cc);
        @(negedge clk);
        in_valid = v;
        a        = ca;
        b        = cb;
        carry_in = cc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        a        = 'x;
        b        = 'x;
        carry_in = 1'bx;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] ra, rb;
        logic        rc, rv;
        int          kind;

        tbl[0] = '{32'h0000_0000, 32'h0000_0004, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{32'hFFFF_FFFC, 32'h0000_0004, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{32'h1234_5678, 32'h0000_0000, 1'b1, 32'h1234_5679, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};

        clear    = 1'b0;
        in_valid = 1'b0;
        a        = 'x;
        b        = 'x;
        carry_in = 1'bx;

        #200;
        chk_all("reset", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        clear = 1'b1;
        idle();
        idle();
        chk_all("post_release_idle", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin);
            chk_all($sformatf("vec%0d", i), 1'b1, tbl[i].s, tbl[i].c, tbl[i].ov, tbl[i].z);
        end

        pc = 32'd0;
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, pc, 32'd4, 1'b0);
            chk($sformatf("pc_inc%0d.sum", i), sum, 32'(4 * i));
            chk($sformatf("pc_inc%0d.valid", i), {31'd0, out_valid}, 32'd1);
            pc = pc + 32'd4;
        end
        chk("pc_final", sum, 32'h0000_0028);

        cycle(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        chk_all("hold_src", 1'b1, 32'd0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk_all($sformatf("hold%0d", i), 1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
        end

        cycle(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        chk_all("pre_async", 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        clear = 1'b0;
        #1;
        chk_all("async_clear", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0);
        chk_all("in_reset_op", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_all("release_idle", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_1000, 32'hFFFF_FFF0, 1'b0);
        model(32'h0000_1000, 32'hFFFF_FFF0, 1'b0);
        chk_all("first_after_reset", 1'b1, m_s, m_c, m_ov, m_z);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 3);
            ra   = $urandom();
            rb   = $urandom();
            rc   = 1'($urandom_range(0, 1));
            rv   = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            case (kind)
                1: rb = 32'd4;
                2: begin
                    ra = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
                    rb = {ra[31], 31'($urandom_range(0, 3))};
                end
                3: begin
                    rb = ~ra + 32'd1 - {31'd0, rc};
                end
                default: ;
            endcase
            if (rv) begin
                model(ra, rb, rc);
                cycle(1'b1, ra, rb, rc);
            end else begin
                idle();
            end
            chk_all($sformatf("rand%0d", i), rv, m_s, m_c, m_ov, m_z);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
